// File: rtl/ppu_pkg.sv
// Shared pipeline definitions: control-word field layout, bubble value and small helpers.
package ppu_pkg;

   localparam int CW_DEF = 15;

   localparam int SHIFT_IMM   = 14;
   localparam int ALU_OP_HI   = 13;
   localparam int ALU_OP_LO   = 11;
   localparam int LOAD        = 10;
   localparam int RF_EN       = 9;
   localparam int BRANCH      = 8;
   localparam int TA          = 7;
   localparam int MEM_SIZE_HI = 6;
   localparam int MEM_SIZE_LO = 5;
   localparam int MEM_RW      = 4;
   localparam int MEM_SE      = 3;
   localparam int HI_EN       = 2;
   localparam int LO_EN       = 1;
   localparam int MEM_EN      = 0;

   localparam logic [CW_DEF-1:0] BUBBLE_CTRL = '0;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } memSizeE;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register holding {valid, ctrl, pc, insn}; a bubble clears the whole word so
// an invalid stage can never carry a live enable.
module pipe_stage_reg
   import ppu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hold_i,
   input  logic         bubble_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   // Priority: reset, then bubble (flush beats a stall hold), then hold, then load.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q <= '0;
      end else if (bubble_i) begin
         data_q <= '0;
      end else if (!hold_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// ID..WB pipeline register chain with per-stage stall/flush, bubble insertion and
// occupancy / bubble statistics.
module pipe_ctrl_chain
   import ppu_pkg::*;
#(
   parameter int STAGES = 4,
   parameter int CW     = CW_DEF,
   parameter int AW     = 32,
   parameter int IW     = 32,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [CW-1:0]        in_ctrl,
   input  logic [AW-1:0]        in_pc,
   input  logic [IW-1:0]        in_insn,
   output logic                 in_ready,
   input  logic                 stall_en,
   input  logic [2:0]           stall_at,
   input  logic [STAGES-1:0]    flush,
   output logic [STAGES-1:0]    stg_valid,
   output logic [STAGES*CW-1:0] stg_ctrl,
   output logic [STAGES*AW-1:0] stg_pc,
   output logic [STAGES*IW-1:0] stg_insn,
   output logic                 retire_valid,
   output logic [3:0]           occupancy,
   output logic [CNT_W-1:0]     bubble_cnt
);

   localparam int W = 1 + CW + AW + IW;

   logic [W-1:0]      stageData [STAGES];
   logic [STAGES-1:0] nextValid;
   logic [3:0]        stallIdx;
   logic              stallAct;
   logic              bubbleIns;
   logic [3:0]        occupancy_q, occupancy_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

   // An out-of-range stall index is ignored entirely; stalling the last stage adds no bubble.
   assign stallIdx  = {1'b0, stall_at};
   assign stallAct  = stall_en && (stallIdx < 4'(STAGES));
   assign bubbleIns = stallAct && (stallIdx < 4'(STAGES - 1));
   assign in_ready  = !stallAct;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic         hold;
      logic         bubble;
      logic [W-1:0] d;

      assign hold   = stallAct && (4'(i) <= stallIdx);
      assign bubble = flush[i] || (bubbleIns && (4'(i) == stallIdx + 4'd1));

      if (i == 0) begin : g_head
         assign d = {in_valid, in_ctrl, in_pc, in_insn};
      end else begin : g_body
         assign d = stageData[i-1];
      end

      pipe_stage_reg #(.W(W)) u_reg (
         .clk      (clk),
         .reset    (reset),
         .hold_i   (hold),
         .bubble_i (bubble),
         .d_i      (d),
         .q_o      (stageData[i])
      );

      assign stg_valid[i]          = stageData[i][W-1];
      assign stg_ctrl[i*CW +: CW]  = stageData[i][AW+IW +: CW];
      assign stg_pc[i*AW +: AW]    = stageData[i][IW +: AW];
      assign stg_insn[i*IW +: IW]  = stageData[i][0 +: IW];
      assign nextValid[i]          = !bubble && (hold ? stageData[i][W-1] : d[W-1]);
   end

   always_comb begin
      occupancy_d  = popcount8(8'(nextValid));
      bubble_cnt_d = bubble_cnt_q;
      if (bubbleIns && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   // Occupancy mirrors the valid bits the stages will hold after this edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         occupancy_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         occupancy_q  <= occupancy_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign occupancy    = occupancy_q;
   assign bubble_cnt   = bubble_cnt_q;
   assign retire_valid = stg_valid[STAGES-1] && !(stall_en && (stall_at == 3'(STAGES - 1)));

endmodule
